// File: rtl/fp_add_arb_pkg.sv
// Shared types for the two-requester floating-point adder arbiter.
package fp_add_arb_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   typedef logic req_idx_t;

endpackage

// File: rtl/fp_add_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant: on a tie, the requester not served last wins.
module rr_arb2
   import fp_add_arb_pkg::*;
(
   input  logic [1:0] valid,
   input  req_idx_t   last_grant,
   output logic       grant_valid,
   output req_idx_t   grant_idx
);

   always_comb begin
      grant_valid = |valid;
      grant_idx   = 1'b0;
      case (valid)
         2'b01:   grant_idx = 1'b0;
         2'b10:   grant_idx = 1'b1;
         2'b11:   grant_idx = ~last_grant;
         default: grant_idx = 1'b0;
      endcase
   end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one combinational FP adder between two valid/ready requesters,
// holding registered operands for ADD_LAT cycles before capturing the sum.
module fp_add_arbiter
   import fp_add_arb_pkg::*;
#(
   parameter int unsigned ADD_LAT = 2,
   parameter int unsigned DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req0_half,
   output logic              resp0_valid,
   input  logic              resp0_ready,
   output logic [DATA_W-1:0] resp0_sum,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic              req1_half,
   output logic              resp1_valid,
   input  logic              resp1_ready,
   output logic [DATA_W-1:0] resp1_sum,
   output logic [DATA_W-1:0] add_a,
   output logic [DATA_W-1:0] add_b,
   output logic              add_sel,
   input  logic [DATA_W-1:0] add_sum,
   output logic              busy
);

   state_t           state, state_nxt;
   req_idx_t         last_grant, grant, arb_idx;
   logic             arb_valid, accept, capture, release_resp;
   logic [CNT_W-1:0] cnt;

   rr_arb2 u_arb (
      .valid       ({req1_valid, req0_valid}),
      .last_grant  (last_grant),
      .grant_valid (arb_valid),
      .grant_idx   (arb_idx)
   );

   always_comb begin
      accept       = (state == IDLE) && arb_valid;
      req0_ready   = accept && (arb_idx == 1'b0);
      req1_ready   = accept && (arb_idx == 1'b1);
      capture      = (state == WAIT) && (cnt == CNT_W'(1));
      resp0_valid  = (state == DONE) && (grant == 1'b0);
      resp1_valid  = (state == DONE) && (grant == 1'b1);
      release_resp = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);
      busy         = (state != IDLE);

      state_nxt = state;
      case (state)
         IDLE:    if (accept)       state_nxt = WAIT;
         WAIT:    if (capture)      state_nxt = DONE;
         DONE:    if (release_resp) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         grant      <= 1'b0;
         cnt        <= '0;
         add_a      <= '0;
         add_b      <= '0;
         add_sel    <= 1'b0;
         resp0_sum  <= '0;
         resp1_sum  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            grant <= arb_idx;
            cnt   <= CNT_W'(ADD_LAT);
            if (arb_idx == 1'b1) begin
               add_a   <= req1_a;
               add_b   <= req1_b;
               add_sel <= req1_half;
            end else begin
               add_a   <= req0_a;
               add_b   <= req0_b;
               add_sel <= req0_half;
            end
         end else if (state == WAIT) begin
            cnt <= cnt - CNT_W'(1);
         end
         // Sum is sampled on the last WAIT cycle, after ADD_LAT cycles of stable inputs.
         if (capture) begin
            if (grant == 1'b1) resp1_sum <= add_sum;
            else               resp0_sum <= add_sum;
         end
         if (release_resp) last_grant <= grant;
      end
   end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter with a simple positive-operand FP adder model.
module tb_fp_add_arbiter;

   localparam int unsigned ADD_LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req0_ready, req0_half = 1'b0;
   logic [31:0] req0_a = '0, req0_b = '0;
   logic        resp0_valid, resp0_ready = 1'b1;
   logic [31:0] resp0_sum;
   logic        req1_valid = 1'b0, req1_ready, req1_half = 1'b0;
   logic [31:0] req1_a = '0, req1_b = '0;
   logic        resp1_valid, resp1_ready = 1'b1;
   logic [31:0] resp1_sum;
   logic [31:0] add_a, add_b, add_sum;
   logic        add_sel, busy;

   typedef struct {
      int          idx;
      logic [31:0] sum;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   hs_cyc   = 0;
   logic pv0 = 1'b0, pv1 = 1'b0;

   fp_add_arbiter #(.ADD_LAT(ADD_LAT), .DATA_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_half   (req0_half),
      .resp0_valid (resp0_valid),
      .resp0_ready (resp0_ready),
      .resp0_sum   (resp0_sum),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_half   (req1_half),
      .resp1_valid (resp1_valid),
      .resp1_ready (resp1_ready),
      .resp1_sum   (resp1_sum),
      .add_a       (add_a),
      .add_b       (add_b),
      .add_sel     (add_sel),
      .add_sum     (add_sum),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Adder stand-in: positive normal operands, exact (truncating) alignment.
   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b, input logic half);
      int unsigned mw, ew;
      logic [31:0] mask, ea, eb, ma, mb, t, s;
      mw   = half ? 10 : 23;
      ew   = half ? 5 : 8;
      mask = (32'd1 << mw) - 32'd1;
      ea   = (a >> mw) & ((32'd1 << ew) - 32'd1);
      eb   = (b >> mw) & ((32'd1 << ew) - 32'd1);
      ma   = (a & mask) | (32'd1 << mw);
      mb   = (b & mask) | (32'd1 << mw);
      if (ea < eb) begin
         t = ea; ea = eb; eb = t;
         t = ma; ma = mb; mb = t;
      end
      mb = mb >> (ea - eb);
      s  = ma + mb;
      if ((s >> (mw + 1)) != 32'd0) begin
         s  = s >> 1;
         ea = ea + 32'd1;
      end
      return (ea << mw) | (s & mask);
   endfunction

   always_comb add_sum = fp_add(add_a, add_b, add_sel);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_req(input int idx, input logic v, input logic [31:0] a, input logic [31:0] b, input logic h);
      if (idx == 0) begin
         req0_valid = v; req0_a = a; req0_b = b; req0_half = h;
      end else begin
         req1_valid = v; req1_a = a; req1_b = b; req1_half = h;
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"},        32'(busy),        32'd0);
      chk({tag, "_req0_ready"},  32'(req0_ready),  32'd0);
      chk({tag, "_req1_ready"},  32'(req1_ready),  32'd0);
      chk({tag, "_resp0_valid"}, 32'(resp0_valid), 32'd0);
      chk({tag, "_resp1_valid"}, 32'(resp1_valid), 32'd0);
      chk({tag, "_add_a"},       add_a,            32'd0);
      chk({tag, "_add_b"},       add_b,            32'd0);
      chk({tag, "_add_sel"},     32'(add_sel),     32'd0);
      chk({tag, "_resp0_sum"},   resp0_sum,        32'd0);
      chk({tag, "_resp1_sum"},   resp1_sum,        32'd0);
   endtask

   task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b, input logic half,
                        input logic [31:0] sum, input bit hold_chk, output int waited);
      exp_t e;
      e.idx = idx;
      e.sum = sum;
      exp_q.push_back(e);
      @(posedge clk); #2;
      set_req(idx, 1'b1, a, b, half);
      waited = 0;
      while (1) begin
         @(negedge clk);
         if ((idx == 0) ? req0_ready : req1_ready) break;
         waited++;
         if (waited > 100) begin
            n_checks++; n_fail++;
            $display("FAIL issue_timeout: req%0d never granted", idx);
            break;
         end
      end
      @(posedge clk); #2;
      // Scramble the request after the handshake; the adder inputs must not follow it.
      set_req(idx, 1'b0, 32'hDEADBEEF, 32'h12345678, ~half);
      if (hold_chk) begin
         for (int k = 0; k < int'(ADD_LAT); k++) begin
            @(negedge clk);
            chk("hold_add_a",   add_a,         a);
            chk("hold_add_b",   add_b,         b);
            chk("hold_add_sel", 32'(add_sel),  32'(half));
            chk("hold_busy",    32'(busy),     32'd1);
         end
      end
   endtask

   task automatic run_both(output int first);
      logic g0, g1;
      bit   got_first;
      int   t;
      got_first = 0;
      first = -1;
      t = 0;
      while ((req0_valid || req1_valid) && t < 100) begin
         @(negedge clk);
         g0 = req0_ready;
         g1 = req1_ready;
         if (!got_first && (g0 || g1)) begin
            first = g0 ? 0 : 1;
            got_first = 1;
         end
         @(posedge clk); #2;
         if (g0) req0_valid = 1'b0;
         if (g1) req1_valid = 1'b0;
         t++;
      end
      if (t >= 100) begin
         n_checks++; n_fail++;
         $display("FAIL run_both_timeout: requests left pending");
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || busy) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         n_checks++; n_fail++;
         $display("FAIL idle_timeout: %0d responses outstanding, busy=%0b", exp_q.size(), busy);
      end
   endtask

   // Monitor: latency, requester routing and result values against the scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         pv0 = 1'b0;
         pv1 = 1'b0;
      end else begin
         if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) hs_cyc = cyc;
         chk("dual_ready", 32'(req0_ready && req1_ready), 32'd0);
         if (resp0_valid || resp1_valid) begin
            if (!(pv0 || pv1)) chk("resp_latency", 32'(cyc - hs_cyc), 32'(ADD_LAT + 1));
            chk("dual_resp_valid", 32'(resp0_valid && resp1_valid), 32'd0);
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_resp: resp0_valid=%0b resp1_valid=%0b, expected none", resp0_valid, resp1_valid);
            end else begin
               chk("resp_idx", 32'(resp1_valid ? 1 : 0), 32'(exp_q[0].idx));
               if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
                  chk("resp_sum", resp1_valid ? resp1_sum : resp0_sum, exp_q[0].sum);
                  void'(exp_q.pop_front());
               end
            end
         end
         pv0 = resp0_valid;
         pv1 = resp1_valid;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   waited, first;
      exp_t e;

      #1;
      check_reset_vals("rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_vals("post_rst");

      // Simultaneous requests: req0 wins the first tie, then alternation continues.
      e.idx = 0; e.sum = 32'h40000000; exp_q.push_back(e);
      e.idx = 1; e.sum = 32'h40800000; exp_q.push_back(e);
      @(posedge clk); #2;
      set_req(0, 1'b1, 32'h3F800000, 32'h3F800000, 1'b0);
      set_req(1, 1'b1, 32'h40000000, 32'h40000000, 1'b0);
      run_both(first);
      chk("tie_first_grant", 32'(first), 32'd0);
      wait_idle();
      e.idx = 0; e.sum = 32'h40000000; exp_q.push_back(e);
      e.idx = 1; e.sum = 32'h40800000; exp_q.push_back(e);
      @(posedge clk); #2;
      set_req(0, 1'b1, 32'h3F800000, 32'h3F800000, 1'b0);
      set_req(1, 1'b1, 32'h40000000, 32'h40000000, 1'b0);
      run_both(first);
      chk("tie_second_grant", 32'(first), 32'd0);
      wait_idle();

      // Single 32-bit op: 1.0 + 2.0.
      issue(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b1, waited);
      chk("single_ready_immediate", 32'(waited), 32'd0);
      wait_idle();

      // Half mode: 1.0 + 2.0 in binary16.
      issue(1, 32'h00003C00, 32'h00004000, 1'b1, 32'h00004200, 1'b1, waited);
      wait_idle();

      // Backpressure with a competing request pending.
      resp0_ready = 1'b0;
      issue(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b1, waited);
      e.idx = 1; e.sum = 32'h40000000; exp_q.push_back(e);
      set_req(1, 1'b1, 32'h3F800000, 32'h3F800000, 1'b0);
      waited = 0;
      while (!resp0_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      for (int k = 0; k < 5; k++) begin
         chk("bp_resp0_valid", 32'(resp0_valid), 32'd1);
         chk("bp_resp0_sum",   resp0_sum,        32'h40400000);
         chk("bp_req1_ready",  32'(req1_ready),  32'd0);
         chk("bp_busy",        32'(busy),        32'd1);
         @(negedge clk);
      end
      @(posedge clk); #2;
      resp0_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release_idle", 32'(busy),       32'd0);
      chk("bp_next_ready",   32'(req1_ready), 32'd1);
      @(posedge clk); #2;
      req1_valid = 1'b0;
      wait_idle();

      // Reset in the middle of WAIT: response discarded, outputs cleared at once.
      @(posedge clk); #2;
      set_req(0, 1'b1, 32'h3F800000, 32'h40000000, 1'b0);
      waited = 0;
      while (!req0_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      @(posedge clk); #2;
      req0_valid = 1'b0;
      @(negedge clk);
      chk("pre_abort_busy", 32'(busy), 32'd1);
      #1 rst_n = 1'b0;
      #1 check_reset_vals("abort");
      @(posedge clk); #2;
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_no_resp", 32'(resp0_valid || resp1_valid), 32'd0);
      issue(0, 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 1'b1, waited);
      chk("after_abort_ready", 32'(waited), 32'd0);
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
